// File: rtl/larpix_config_responder_pkg.sv
// Shared types for the LArPix config responder: packet layout, declare codes, FSM states.
package larpix_config_responder_pkg;
  localparam int          WIDTH        = 64;
  localparam logic [31:0] MAGIC_NUMBER = 32'h8950_4E47;
  localparam logic [7:0]  GLOBAL_ID    = 8'd255;

  typedef enum logic [1:0] {
    DATA   = 2'd1,
    CFG_WR = 2'd2,
    CFG_RD = 2'd3
  } declare_t;

  typedef struct packed {
    logic        parity;
    logic        downstream;
    logic [3:0]  rsvd;
    logic [31:0] magic;
    logic [7:0]  data;
    logic [7:0]  addr;
    logic [7:0]  chip_id;
    declare_t    declare;
  } packet_t;

  typedef enum logic [3:0] {
    S_IDLE, S_UNLOAD, S_CAPTURE, S_DECODE, S_WRITE, S_RD_ADDR,
    S_RD_DATA, S_BUILD, S_TX_WAIT, S_TX_LOAD, S_TX_HOLD
  } state_t;

  // Value of bit 63 that makes the whole word carry an odd number of ones.
  function automatic logic odd_parity(input logic [WIDTH-2:0] bits);
    return ~^bits;
  endfunction
endpackage

// File: rtl/larpix_config_responder_if.sv
// Bundles the uart_rx, regmap and uart_tx signals seen by the config responder.
interface larpix_config_responder_if;
  import larpix_config_responder_pkg::*;

  logic [WIDTH-1:0] rx_data;
  logic             rx_empty;
  logic             uld_rx_data;
  logic [7:0]       regmap_addr;
  logic [7:0]       regmap_wdata;
  logic             regmap_we;
  logic [7:0]       regmap_rdata;
  logic [WIDTH-1:0] tx_data;
  logic             ld_tx_data;
  logic             tx_busy;

  modport master (
    input  rx_data, rx_empty, regmap_rdata, tx_busy,
    output uld_rx_data, regmap_addr, regmap_wdata, regmap_we, tx_data, ld_tx_data
  );

  modport slave (
    output rx_data, rx_empty, regmap_rdata, tx_busy,
    input  uld_rx_data, regmap_addr, regmap_wdata, regmap_we, tx_data, ld_tx_data
  );
endinterface

// File: rtl/larpix_config_responder.sv
// Chip-side config responder: unloads a word from uart_rx, validates it, performs the register
// write/read and hands a reply word to uart_tx. One packet in flight; uart_rx holds any backlog.
module larpix_config_responder
  import larpix_config_responder_pkg::*;
#(
  parameter int REGNUM = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       chip_id,
  larpix_config_responder_if.master        bus,
  output logic [7:0]                       parity_err_cnt,
  output logic [7:0]                       bad_pkt_cnt
);
  localparam logic [8:0] LP_REGNUM = 9'(REGNUM);

  state_t     r_state;
  state_t     w_state_nxt;
  packet_t    r_pkt;
  packet_t    r_reply;
  logic [7:0] r_perr_cnt;
  logic [7:0] r_bad_cnt;

  logic       w_addr_ok;
  logic       w_parity_ok;
  logic       w_pkt_bad;
  logic       w_for_me;
  logic       w_perr_inc;
  logic       w_bad_inc;
  packet_t    w_body;
  packet_t    w_reply;

  assign w_addr_ok   = ({1'b0, r_pkt.addr} < LP_REGNUM);
  assign w_parity_ok = (r_pkt.parity == odd_parity(r_pkt[WIDTH-2:0]));
  assign w_pkt_bad   = (r_pkt.magic != MAGIC_NUMBER) || (r_pkt.declare < CFG_WR);
  assign w_for_me    = (r_pkt.chip_id == chip_id) || (r_pkt.chip_id == GLOBAL_ID);

  // Reply always carries our own ID, even when answering a broadcast.
  always_comb begin
    w_body            = '0;
    w_body.declare    = r_pkt.declare;
    w_body.chip_id    = chip_id;
    w_body.addr       = r_pkt.addr;
    w_body.magic      = MAGIC_NUMBER;
    w_body.downstream = 1'b1;
    if (r_state == S_WRITE) begin
      w_body.data = r_pkt.data;
    end else begin
      w_body.data = w_addr_ok ? bus.regmap_rdata : 8'h00;
    end
    w_reply = {odd_parity(w_body[WIDTH-2:0]), w_body[WIDTH-2:0]};
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_perr_inc       = 1'b0;
    w_bad_inc        = 1'b0;
    bus.uld_rx_data  = 1'b0;
    bus.regmap_addr  = 8'h00;
    bus.regmap_wdata = 8'h00;
    bus.regmap_we    = 1'b0;
    bus.ld_tx_data   = 1'b0;
    case (r_state)
      S_IDLE:    if (!bus.rx_empty) w_state_nxt = S_UNLOAD;
      S_UNLOAD: begin
        bus.uld_rx_data = 1'b1;
        w_state_nxt     = S_CAPTURE;
      end
      S_CAPTURE: w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (!w_parity_ok) begin
          w_perr_inc  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_pkt_bad) begin
          w_bad_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!w_for_me) begin
          w_state_nxt = S_IDLE;
        end else if (r_pkt.declare == CFG_WR) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_RD_ADDR;
        end
      end
      S_WRITE: begin
        bus.regmap_addr  = r_pkt.addr;
        bus.regmap_wdata = r_pkt.data;
        bus.regmap_we    = w_addr_ok;
        w_state_nxt      = S_BUILD;
      end
      S_RD_ADDR: begin
        bus.regmap_addr = r_pkt.addr;
        w_state_nxt     = S_RD_DATA;
      end
      S_RD_DATA: begin
        bus.regmap_addr = r_pkt.addr;
        w_state_nxt     = S_BUILD;
      end
      S_BUILD:   w_state_nxt = S_TX_WAIT;
      S_TX_WAIT: if (!bus.tx_busy) w_state_nxt = S_TX_LOAD;
      S_TX_LOAD: begin
        bus.ld_tx_data = 1'b1;
        w_state_nxt    = S_TX_HOLD;
      end
      S_TX_HOLD: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Reply is registered on leaving WRITE/RD_DATA so tx_data is steady from BUILD onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pkt      <= '0;
      r_reply    <= '0;
      r_perr_cnt <= 8'h00;
      r_bad_cnt  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CAPTURE) r_pkt <= packet_t'(bus.rx_data);
      if ((r_state == S_WRITE) || (r_state == S_RD_DATA)) r_reply <= w_reply;
      if (w_perr_inc && (r_perr_cnt != 8'hFF)) r_perr_cnt <= r_perr_cnt + 8'd1;
      if (w_bad_inc && (r_bad_cnt != 8'hFF)) r_bad_cnt <= r_bad_cnt + 8'd1;
    end
  end

  assign bus.tx_data     = r_reply;
  assign parity_err_cnt  = r_perr_cnt;
  assign bad_pkt_cnt     = r_bad_cnt;
endmodule

// File: tb/tb_larpix_config_responder.sv
// Bench for larpix_config_responder: uart_rx/regmap/uart_tx models plus a packet-level reference.
module tb_larpix_config_responder;
  import larpix_config_responder_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chip_id;
  logic [7:0] parity_err_cnt;
  logic [7:0] bad_pkt_cnt;

  larpix_config_responder_if bus();

  larpix_config_responder #(.REGNUM(256)) dut (
    .clk(clk), .reset(reset), .chip_id(chip_id), .bus(bus),
    .parity_err_cnt(parity_err_cnt), .bad_pkt_cnt(bad_pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int cool = 0;
  logic [63:0] rx_q[$];
  logic [63:0] tx_q[$];
  int uld_stamp[$];
  int ld_stamp[$];
  int we_stamp[$];
  int present_stamp = 0;
  logic [7:0] mem[256];
  logic [7:0] ref_mem[256];
  logic [7:0] prev_addr = 8'h00;
  int we_n = 0;
  logic [7:0] we_addr, we_data;
  int uld_run = 0, uld_max = 0, ld_run = 0, ld_max = 0;
  int exp_perr = 0, exp_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic flip, input logic ds, input logic [1:0] dec,
                                     input logic [7:0] chip, input logic [7:0] a,
                                     input logic [7:0] d, input logic [31:0] mg);
    logic [63:0] w;
    w = '0;
    w[1:0] = dec; w[9:2] = chip; w[17:10] = a; w[25:18] = d; w[57:26] = mg; w[62] = ds;
    if ($countones(w) % 2 == 0) w[63] = 1'b1;
    w[63] = w[63] ^ flip;
    return w;
  endfunction

  // Packet-level reference: what one received word should do to the chip.
  task automatic model_step(input logic [63:0] w, output int e_we, output int e_ld,
                            output logic [63:0] e_reply);
    logic [1:0] dec; logic [7:0] chip, a, d; logic [31:0] mg;
    dec = w[1:0]; chip = w[9:2]; a = w[17:10]; d = w[25:18]; mg = w[57:26];
    e_we = 0; e_ld = 0; e_reply = '0;
    if ($countones(w) % 2 == 0) begin
      if (exp_perr < 255) exp_perr++;
    end else if (mg != MAGIC_NUMBER || dec < 2'd2) begin
      if (exp_bad < 255) exp_bad++;
    end else if (chip == chip_id || chip == 8'd255) begin
      e_ld = 1;
      if (dec == 2'd2) begin
        e_we = 1;
        ref_mem[a] = d;
        e_reply = mk(1'b0, 1'b1, 2'd2, chip_id, a, d, MAGIC_NUMBER);
      end else begin
        e_reply = mk(1'b0, 1'b1, 2'd3, chip_id, a, ref_mem[a], MAGIC_NUMBER);
      end
    end
  endtask

  // uart_rx, regmap and uart_tx models, all acting on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.uld_rx_data) begin
      bus.rx_empty = 1'b1;
      cool = 3;
      uld_stamp.push_back(cyc);
      uld_run++;
    end else begin
      uld_run = 0;
      if (cool > 0) cool--;
      else if (bus.rx_empty && rx_q.size() > 0) begin
        bus.rx_data  = rx_q.pop_front();
        bus.rx_empty = 1'b0;
        present_stamp = cyc;
      end
    end
    if (uld_run > uld_max) uld_max = uld_run;
    if (bus.regmap_we) begin
      mem[bus.regmap_addr] = bus.regmap_wdata;
      we_n++; we_addr = bus.regmap_addr; we_data = bus.regmap_wdata;
      we_stamp.push_back(cyc);
    end
    bus.regmap_rdata = mem[prev_addr];
    prev_addr = bus.regmap_addr;
    if (bus.ld_tx_data) begin
      tx_q.push_back(bus.tx_data);
      ld_stamp.push_back(cyc);
      ld_run++;
    end else ld_run = 0;
    if (ld_run > ld_max) ld_max = ld_run;
  end

  typedef struct {
    string       name;
    logic [63:0] word;
    int          n_we;
    logic [7:0]  w_addr;
    logic [7:0]  w_data;
    int          n_ld;
    logic [63:0] reply;
    int          perr;
    int          bad;
  } vec_t;

  vec_t vt[$];

  initial begin
    int e_we, e_ld, k;
    logic [63:0] e_rep, w1, w2, r1, r2, w;
    logic ok;
    reset = 1'b1; chip_id = 8'h00; bus.tx_busy = 1'b0;
    bus.rx_empty = 1'b1; bus.rx_data = '0; bus.regmap_rdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end

    vt.push_back('{"wr_a5", mk(0,0,2,8'd0,8'h10,8'hA5,MAGIC_NUMBER), 1, 8'h10, 8'hA5, 1,
                   mk(0,1,2,8'd0,8'h10,8'hA5,MAGIC_NUMBER), 0, 0});
    vt.push_back('{"rd_a5", mk(0,0,3,8'd0,8'h10,8'h00,MAGIC_NUMBER), 0, 8'h00, 8'h00, 1,
                   mk(0,1,3,8'd0,8'h10,8'hA5,MAGIC_NUMBER), 0, 0});
    vt.push_back('{"par_flip", mk(1,0,2,8'd0,8'h10,8'h5A,MAGIC_NUMBER), 0, 8'h00, 8'h00, 0,
                   64'h0, 1, 0});
    vt.push_back('{"id16", mk(0,0,2,8'd16,8'h10,8'h5A,MAGIC_NUMBER), 0, 8'h00, 8'h00, 0,
                   64'h0, 1, 0});
    vt.push_back('{"bcast", mk(0,0,2,8'd255,8'h20,8'h3C,MAGIC_NUMBER), 1, 8'h20, 8'h3C, 1,
                   mk(0,1,2,8'd0,8'h20,8'h3C,MAGIC_NUMBER), 1, 0});
    vt.push_back('{"magic0", mk(0,0,2,8'd0,8'h10,8'h5A,32'h0), 0, 8'h00, 8'h00, 0,
                   64'h0, 1, 1});
    vt.push_back('{"decl0", mk(0,0,0,8'd0,8'h10,8'h5A,MAGIC_NUMBER), 0, 8'h00, 8'h00, 0,
                   64'h0, 1, 2});
    vt.push_back('{"decl1", mk(0,0,1,8'd0,8'h10,8'h5A,MAGIC_NUMBER), 0, 8'h00, 8'h00, 0,
                   64'h0, 1, 3});
    vt.push_back('{"rd_init", mk(0,0,3,8'd0,8'h33,8'h00,MAGIC_NUMBER), 0, 8'h00, 8'h00, 1,
                   mk(0,1,3,8'd0,8'h33,8'h0F,MAGIC_NUMBER), 1, 3});
    vt.push_back('{"rd_again", mk(0,0,3,8'd0,8'h10,8'h00,MAGIC_NUMBER), 0, 8'h00, 8'h00, 1,
                   mk(0,1,3,8'd0,8'h10,8'hA5,MAGIC_NUMBER), 1, 3});
    vt.push_back('{"par_over_magic", mk(1,0,2,8'd0,8'h10,8'h00,32'h0), 0, 8'h00, 8'h00, 0,
                   64'h0, 2, 3});

    repeat (3) @(negedge clk);
    #1;
    chk("rst_uld", bus.uld_rx_data, 0);
    chk("rst_we", bus.regmap_we, 0);
    chk("rst_addr", bus.regmap_addr, 0);
    chk("rst_wdata", bus.regmap_wdata, 0);
    chk("rst_ld", bus.ld_tx_data, 0);
    chk("rst_txdata", bus.tx_data, 0);
    chk("rst_perr", parity_err_cnt, 0);
    chk("rst_bad", bad_pkt_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vt[i]) begin
      model_step(vt[i].word, e_we, e_ld, e_rep);
      we_n = 0; tx_q.delete();
      rx_q.push_back(vt[i].word);
      repeat (20) @(negedge clk);
      chk({vt[i].name, "_we_n"}, we_n, vt[i].n_we);
      if (vt[i].n_we > 0) begin
        chk({vt[i].name, "_we_addr"}, we_addr, vt[i].w_addr);
        chk({vt[i].name, "_we_data"}, we_data, vt[i].w_data);
      end
      chk({vt[i].name, "_ld_n"}, tx_q.size(), vt[i].n_ld);
      if (vt[i].n_ld > 0) chk({vt[i].name, "_reply"}, (tx_q.size() > 0) ? tx_q[0] : 64'h0, vt[i].reply);
      chk({vt[i].name, "_perr"}, parity_err_cnt, vt[i].perr);
      chk({vt[i].name, "_bad"}, bad_pkt_cnt, vt[i].bad);
    end

    // Latency from rx_empty falling to the write strobe and to the reply load.
    w = mk(0,0,2,8'd0,8'h40,8'h77,MAGIC_NUMBER);
    model_step(w, e_we, e_ld, e_rep);
    we_stamp.delete(); ld_stamp.delete(); tx_q.delete();
    rx_q.push_back(w);
    repeat (20) @(negedge clk);
    chk("lat_we", (we_stamp.size() > 0) ? 64'(we_stamp[0] - present_stamp) : 64'hFFFF, 4);
    chk("lat_ld", (ld_stamp.size() > 0) ? 64'(ld_stamp[0] - present_stamp) : 64'hFFFF, 7);
    chk("lat_reply", (tx_q.size() > 0) ? tx_q[0] : 64'h0, e_rep);

    // Reply held off by tx_busy while a second word waits in uart_rx.
    w1 = mk(0,0,2,8'd0,8'h50,8'h11,MAGIC_NUMBER);
    w2 = mk(0,0,2,8'd0,8'h51,8'h22,MAGIC_NUMBER);
    model_step(w1, e_we, e_ld, r1);
    model_step(w2, e_we, e_ld, r2);
    uld_stamp.delete(); ld_stamp.delete(); tx_q.delete();
    bus.tx_busy = 1'b1;
    rx_q.push_back(w1); rx_q.push_back(w2);
    repeat (50) @(negedge clk);
    chk("busy_uld_n", uld_stamp.size(), 1);
    chk("busy_ld_n", ld_stamp.size(), 0);
    chk("busy_rx_pending", bus.rx_empty, 0);
    bus.tx_busy = 1'b0;
    repeat (30) @(negedge clk);
    chk("rel_ld_n", ld_stamp.size(), 2);
    chk("rel_uld_n", uld_stamp.size(), 2);
    ok = (uld_stamp.size() >= 2 && ld_stamp.size() >= 1) ? (uld_stamp[1] > ld_stamp[0]) : 1'b0;
    chk("rel_order", ok, 1);
    chk("rel_reply0", (tx_q.size() > 0) ? tx_q[0] : 64'h0, r1);
    chk("rel_reply1", (tx_q.size() > 1) ? tx_q[1] : 64'h0, r2);

    // 300 bad-magic words: bad_pkt_cnt must stick at 8'hFF.
    for (int i = 0; i < 300; i++) begin
      w = mk(0,0,2,8'd0,8'h00,8'h00,32'h0);
      model_step(w, e_we, e_ld, e_rep);
      rx_q.push_back(w);
    end
    k = 0;
    while ((rx_q.size() > 0 || !bus.rx_empty) && k < 5000) begin
      @(negedge clk); k++;
    end
    if (k >= 5000) begin
      n_chk++; n_fail++;
      $display("FAIL sat_drain: rx backlog not drained within 5000 cycles");
    end
    repeat (10) @(negedge clk);
    chk("sat_bad", bad_pkt_cnt, 8'hFF);
    chk("sat_bad_model", bad_pkt_cnt, exp_bad);
    chk("sat_perr", parity_err_cnt, exp_perr);

    // Reset while the read is waiting for regmap_rdata.
    tx_q.delete(); we_n = 0;
    rx_q.push_back(mk(0,0,3,8'd0,8'h10,8'h00,MAGIC_NUMBER));
    k = 0;
    do begin
      @(posedge clk); #2; k++;
    end while (!bus.uld_rx_data && k < 50);
    if (!bus.uld_rx_data) begin
      n_chk++; n_fail++;
      $display("FAIL rst_rd_wait: no unload within 50 cycles");
    end
    repeat (4) @(posedge clk);
    #2;
    chk("rd_data_addr", bus.regmap_addr, 8'h10);
    reset = 1'b1;
    #1;
    chk("midrst_uld", bus.uld_rx_data, 0);
    chk("midrst_we", bus.regmap_we, 0);
    chk("midrst_addr", bus.regmap_addr, 0);
    chk("midrst_ld", bus.ld_tx_data, 0);
    chk("midrst_txdata", bus.tx_data, 0);
    chk("midrst_bad", bad_pkt_cnt, 0);
    exp_perr = 0; exp_bad = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_reply", tx_q.size(), 0);
    chk("midrst_no_write", we_n, 0);

    // Randomized words against the reference model, with a non-zero chip ID.
    chip_id = 8'h5C;
    for (int n = 0; n < 200; n++) begin
      int r; logic [1:0] dec; logic [7:0] chip; logic [31:0] mg;
      r = $urandom_range(0, 9);
      dec = (r < 1) ? 2'd0 : (r < 2) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 3);
      chip = (r < 2) ? chip_id : (r == 2) ? 8'd255 : 8'($urandom);
      mg = ($urandom_range(0, 9) == 0) ? $urandom : MAGIC_NUMBER;
      w = mk(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), dec, chip,
             8'($urandom_range(0, 15)), 8'($urandom), mg);
      model_step(w, e_we, e_ld, e_rep);
      we_n = 0; tx_q.delete();
      rx_q.push_back(w);
      repeat (16) @(negedge clk);
      chk("rnd_we_n", we_n, e_we);
      if (e_we > 0) begin
        chk("rnd_we_addr", we_addr, w[17:10]);
        chk("rnd_we_data", we_data, w[25:18]);
      end
      chk("rnd_ld_n", tx_q.size(), e_ld);
      if (e_ld > 0) chk("rnd_reply", (tx_q.size() > 0) ? tx_q[0] : 64'h0, e_rep);
      chk("rnd_perr", parity_err_cnt, exp_perr);
      chk("rnd_bad", bad_pkt_cnt, exp_bad);
    end

    chk("uld_width", uld_max, 1);
    chk("ld_width", ld_max, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
